por_sequencer: RTL and testbench
================================

POR_SEQUENCER -- requirements
Module: por_sequencer

Interface
REQ-001: The block SHALL have parameter STAGE_DELAY, default 16: clock cycles before each stage release; 0 treated as 1.
REQ-002: The block SHALL have parameter CNT_W, default 16: delay/timeout counter width; STAGE_DELAY and ACK_TIMEOUT < 2^CNT_W.
REQ-003: The block SHALL have parameter ACK_TIMEOUT, default 1024: cycles allowed per stage acknowledge (ACK_EN builds only).
REQ-004: The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005: The block SHALL have port resetb  input  1  asynchronous active-low reset, driven from the power-on-reset porb.
REQ-006: The block SHALL have port ext_resetb  input  1  asynchronous active-low external reset request (pad); synchronized internally.
REQ-007: The block SHALL have port sw_reset  input  1  synchronous single-cycle software reset request, active-high.
REQ-008: The block SHALL have port stage_ack  input  4  per-stage ready (e.g. PLL lock); ignored without ACK_EN.
REQ-009: The block SHALL have port rstb_out  output  4  staged active-low domain resets; bit 0 releases first.
REQ-010: The block SHALL have port seq_done  output  1  high when all four stages are released.
REQ-011: The block SHALL have port seq_fault  output  4  sticky per-stage acknowledge-timeout flags.

Function
REQ-012: ext_resetb SHALL pass a 2-flop synchronizer (flops reset to 0) producing ext_sync; no other input is synchronized.
REQ-013: The FSM SHALL have states HOLD, DLY, ACK, DONE, with stage index k (0..3) and counter cnt.
REQ-014: HOLD: rstb_out=4'b0000, cnt=0, k=0; go to DLY on the first edge with ext_sync=1 and sw_reset=0.
REQ-015: DLY: cnt increments each cycle; on the edge where cnt==STAGE_DELAY-1, rstb_out[k] SHALL go 1, cnt clears, and the FSM goes to ACK (ACK_EN) or else to DLY with k+1 (k<3) or DONE (k==3).
REQ-016: Released stages SHALL stay released; rstb_out bits change only as a monotonic thermometer 0000, 0001, 0011, 0111, 1111 outside a reset request.
REQ-017: DONE: seq_done=1, FSM holds; seq_done SHALL be 0 in every other state.
REQ-018: A reset request (ext_sync=0 or sw_reset=1) in any state SHALL, on the next edge, drive rstb_out=0000, seq_done=0, cnt=0, k=0 and enter HOLD.
REQ-019: A reset request coincident with a stage release edge SHALL take priority; that stage stays asserted.
REQ-020: seq_fault SHALL be unaffected by reset requests; only resetb clears it.
REQ-021: The counter SHALL saturate, never wrap; no compare value exceeds 2^CNT_W-1.

Reset
REQ-022: While resetb=0: rstb_out=0000, seq_done=0, seq_fault=0000, synchronizer flops=0, state HOLD, cnt=0, k=0.
REQ-023: resetb assertion SHALL act asynchronously; deassertion is taken on clk edges only, with no output change on the deasserting edge.

Configuration
REQ-024: Macro POR_SEQ_ACK_EN SHALL select acknowledge handshaking; the ACK state and ACK_TIMEOUT logic exist only when it is defined.
REQ-025: With POR_SEQ_ACK_EN: in ACK, when stage_ack[k]=1 the FSM SHALL advance (DLY with k+1, or DONE if k==3) on that edge, cnt cleared.
REQ-026: With POR_SEQ_ACK_EN: if cnt reaches ACK_TIMEOUT-1 without stage_ack[k], seq_fault[k] SHALL set and the FSM advances as in REQ-025.
REQ-027: Without POR_SEQ_ACK_EN: stage_ack SHALL be ignored, seq_fault SHALL be constant 0000, stages are spaced purely by STAGE_DELAY.

Verification
REQ-028: No ACK_EN, STAGE_DELAY=4, ext_resetb=1, release resetb -> ext_sync at edge 2, DLY at edge 3, rstb_out 0001/0011/0111/1111 at edges 7/11/15/19, seq_done=1 at edge 19.
REQ-029: Same setup, ext_resetb low 3 cycles after rstb_out=0011 -> rstb_out=0000 within 3 edges of the falling input, re-sequence restarts 2 edges after ext_resetb returns high.
REQ-030: sw_reset pulsed 1 cycle in DONE -> next edge rstb_out=0000, seq_done=0, FSM in HOLD, full re-sequence follows.
REQ-031: ACK_EN, ACK_TIMEOUT=8, stage_ack=4'b1101 held -> stage 1 times out after 8 ACK cycles, seq_fault=0010, sequence reaches 1111 and seq_done=1.
REQ-032: ACK_EN, seq_fault=0010, ext_resetb pulse low -> seq_fault stays 0010; resetb pulse low -> seq_fault=0000 immediately, without a clock edge.
REQ-033: sw_reset coincident with stage-2 release edge -> rstb_out goes 0000, never 0111.

Source files
------------

// File: rtl/por_sequencer.sv
// -----------------------------------------------------------------------------
// por_sequencer
//
// Power-on reset sequencer. After the power-on reset (resetb) is released and
// the external reset pad (ext_resetb) is seen high, four domain resets are
// released one at a time. Bit 0 is released first, then 1, 2 and 3, with
// STAGE_DELAY clocks before each release. A reset request from the pad or from
// software drops every domain back into reset and restarts the sequence.
//
// Optional feature (macro POR_SEQ_ACK_EN):
//   After each release the sequencer waits for stage_ack[k] before it moves on
//   to the next stage. If no acknowledge arrives within ACK_TIMEOUT cycles,
//   the sticky seq_fault[k] flag is set and the sequence carries on.
//   When the macro is not defined, stage_ack is ignored and seq_fault is 0.
//
// Parameters:
//   STAGE_DELAY  clocks before each stage release (0 behaves as 1)
//   CNT_W        width of the delay/timeout counter
//   ACK_TIMEOUT  clocks allowed for each stage acknowledge (0 behaves as 1)
//
// Ports:
//   clk         in   sole clock, rising edge
//   resetb      in   async active-low power-on reset
//   ext_resetb  in   async active-low external reset request (synchronized here)
//   sw_reset    in   sync active-high single-cycle software reset request
//   stage_ack   in   [3:0] per-stage ready
//   rstb_out    out  [3:0] staged active-low domain resets (thermometer)
//   seq_done    out  all four stages released
//   seq_fault   out  [3:0] sticky per-stage acknowledge timeout flags
// -----------------------------------------------------------------------------
module por_sequencer #(
    parameter int STAGE_DELAY = 16,
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       ext_resetb,
    input  logic       sw_reset,
    input  logic [3:0] stage_ack,
    output logic [3:0] rstb_out,
    output logic       seq_done,
    output logic [3:0] seq_fault
);

    // Terminal counts. A zero delay or timeout is treated as one cycle.
    localparam int               DLY_EFF  = (STAGE_DELAY < 1) ? 1 : STAGE_DELAY;
    localparam int               ACK_EFF  = (ACK_TIMEOUT < 1) ? 1 : ACK_TIMEOUT;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_EFF - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_DLY  = 2'd1,
        ST_DONE = 2'd2
`ifdef POR_SEQ_ACK_EN
        ,
        ST_ACK  = 2'd3
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       rstb_out_q, rstb_out_d;
    logic             seq_done_q, seq_done_d;
    logic             ext_meta_q, ext_sync_q;
    logic             reset_req;

    // A pad reset or a software pulse drops every domain back into reset.
    assign reset_req = !ext_sync_q || sw_reset;

    // The counter saturates rather than wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef POR_SEQ_ACK_EN
    logic [3:0] fault_q, fault_d;
    assign seq_fault = fault_q;
`else
    logic unused_ack;
    assign seq_fault  = 4'b0000;
    assign unused_ack = ^{stage_ack, ACK_LAST};
`endif

    assign rstb_out = rstb_out_q;
    assign seq_done = seq_done_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        rstb_out_d = rstb_out_q;
        seq_done_d = seq_done_q;
`ifdef POR_SEQ_ACK_EN
        fault_d    = fault_q;
`endif
        if (reset_req) begin
            // This takes priority over a stage release on the same edge.
            state_d    = ST_HOLD;
            k_d        = 2'd0;
            cnt_d      = '0;
            rstb_out_d = 4'b0000;
            seq_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    state_d = ST_DLY;
                    k_d     = 2'd0;
                    cnt_d   = '0;
                end
                ST_DLY: begin
                    if (cnt_q == DLY_LAST) begin
                        rstb_out_d[k_q] = 1'b1;
                        cnt_d           = '0;
`ifdef POR_SEQ_ACK_EN
                        state_d = ST_ACK;
`else
                        if (k_q == 2'd3) begin
                            state_d    = ST_DONE;
                            seq_done_d = 1'b1;
                        end else begin
                            k_d = k_q + 2'd1;
                        end
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`ifdef POR_SEQ_ACK_EN
                ST_ACK: begin
                    // Move on when the stage acknowledges, or when it times out.
                    // A timeout also sets that stage's sticky fault flag.
                    if (stage_ack[k_q] || (cnt_q == ACK_LAST)) begin
                        if (!stage_ack[k_q]) begin
                            fault_d[k_q] = 1'b1;
                        end
                        cnt_d = '0;
                        if (k_q == 2'd3) begin
                            state_d    = ST_DONE;
                            seq_done_d = 1'b1;
                        end else begin
                            state_d = ST_DLY;
                            k_d     = k_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
                ST_DONE: begin
                    seq_done_d = 1'b1;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
            state_q    <= ST_HOLD;
            k_q        <= 2'd0;
            cnt_q      <= '0;
            rstb_out_q <= 4'b0000;
            seq_done_q <= 1'b0;
`ifdef POR_SEQ_ACK_EN
            fault_q    <= 4'b0000;
`endif
        end else begin
            ext_meta_q <= ext_resetb;
            ext_sync_q <= ext_meta_q;
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            rstb_out_q <= rstb_out_d;
            seq_done_q <= seq_done_d;
`ifdef POR_SEQ_ACK_EN
            fault_q    <= fault_d;
`endif
        end
    end

endmodule

// File: tb/tb_por_sequencer.sv
// -----------------------------------------------------------------------------
// tb_por_sequencer
//
// Directed bench for por_sequencer with STAGE_DELAY=4 and ACK_TIMEOUT=8.
// The driver pushes the expected output change for every action onto exp_q.
// Each entry holds {edge number, rstb_out, seq_done, seq_fault}. A monitor
// samples the outputs 1 ns after every rising edge. Each time the outputs
// change, it pops the next entry and compares both the value and the edge at
// which the change happened.
// Edge numbering: edge_n counts rising edges. A release driven at the negedge
// after edge B makes "edge 1" of a sequence equal to B+1.
// -----------------------------------------------------------------------------
module tb_por_sequencer;

    localparam int W = 41;
`ifdef POR_SEQ_ACK_EN
    localparam int GAP     = 5;   // release-to-release spacing when acks arrive at once
    localparam int DONE_AT = 23;  // seq_done edge relative to sequence base
`else
    localparam int GAP     = 4;
    localparam int DONE_AT = 19;
`endif

    logic       clk;
    logic       resetb;
    logic       ext_resetb;
    logic       sw_reset;
    logic [3:0] stage_ack;
    logic [3:0] rstb_out;
    logic       seq_done;
    logic [3:0] seq_fault;

    int         edge_n = 0;
    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] exp_q[$];
    logic [3:0] exp_fault = 4'b0000;
    logic [8:0] last_obs = 9'd0;
    logic [3:0] therm [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    por_sequencer #(
        .STAGE_DELAY(4),
        .CNT_W      (16),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .ext_resetb(ext_resetb),
        .sw_reset  (sw_reset),
        .stage_ack (stage_ack),
        .rstb_out  (rstb_out),
        .seq_done  (seq_done),
        .seq_fault (seq_fault)
    );

    // ---------------- clock / edge counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations left", exp_q.size());
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_edge(input int t);
        while (edge_n < t) @(negedge clk);
    endtask

    task automatic push_ev(input int e, input logic [3:0] r, input logic d);
        exp_q.push_back({32'(e), r, d, exp_fault});
    endtask

    // Expected events for a full sequence whose "edge 1" is base+1, with all acks present.
    task automatic push_sequence(input int base);
        for (int i = 0; i < 4; i++) begin
`ifdef POR_SEQ_ACK_EN
            push_ev(base + 7 + GAP * i, therm[i], 1'b0);
`else
            push_ev(base + 7 + GAP * i, therm[i], (i == 3));
`endif
        end
`ifdef POR_SEQ_ACK_EN
        push_ev(base + DONE_AT, 4'b1111, 1'b1);
`endif
    endtask

    task automatic check_now(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got rstb/done/fault %b expected %b", name, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [8:0]   cur;
        logic [W-1:0] exp;
        #1;
        cur = {rstb_out, seq_done, seq_fault};
        if (cur !== last_obs) begin
            last_obs = cur;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: edge %0d got rstb/done/fault %b, nothing expected",
                         edge_n, cur);
            end else begin
                exp = exp_q.pop_front();
                if ({32'(edge_n), cur} !== exp) begin
                    errors++;
                    $display("FAIL output_change: got edge %0d rstb/done/fault %b expected edge %0d %b",
                             edge_n, cur, exp[40:9], exp[8:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base, s1, r, d, rel2, f, g;
        resetb     = 1'b1;
        ext_resetb = 1'b1;
        sw_reset   = 1'b0;
`ifdef POR_SEQ_ACK_EN
        stage_ack  = 4'b1101;
`else
        stage_ack  = 4'b0101;   // must have no effect in this build
`endif
        #1 resetb = 1'b0;
        wait_edge(3);
        check_now("reset_state", {rstb_out, seq_done, seq_fault}, 9'd0);

        // Power-on release and the first full sequence.
        base   = edge_n;
        resetb = 1'b1;
`ifdef POR_SEQ_ACK_EN
        // Stage 1 never acknowledges: it times out after 8 ACK cycles.
        push_ev(base + 7,  4'b0001, 1'b0);
        push_ev(base + 12, 4'b0011, 1'b0);
        exp_fault = 4'b0010;
        push_ev(base + 20, 4'b0011, 1'b0);
        push_ev(base + 24, 4'b0111, 1'b0);
        push_ev(base + 29, 4'b1111, 1'b0);
        push_ev(base + 30, 4'b1111, 1'b1);
        wait_edge(base + 30);
        stage_ack = 4'b1111;
`else
        push_sequence(base);
        wait_edge(base + DONE_AT);
`endif

        // Software reset pulse while DONE.
        d = edge_n;
        sw_reset = 1'b1;
        push_ev(d + 1, 4'b0000, 1'b0);
        wait_edge(d + 1);
        sw_reset = 1'b0;
        base = d - 1;
        push_ev(base + 7, 4'b0001, 1'b0);
        push_ev(base + 7 + GAP, 4'b0011, 1'b0);

        // Pad reset held low for 3 cycles once two stages are released.
        s1 = base + 7 + GAP;
        wait_edge(s1);
        ext_resetb = 1'b0;
        push_ev(s1 + 3, 4'b0000, 1'b0);
        wait_edge(s1 + 3);
        ext_resetb = 1'b1;
        r = edge_n;
        push_sequence(r);
        wait_edge(r + DONE_AT);

        // Software reset on the same edge as the stage-2 release.
        d = edge_n;
        sw_reset = 1'b1;
        push_ev(d + 1, 4'b0000, 1'b0);
        wait_edge(d + 1);
        sw_reset = 1'b0;
        base = d - 1;
        push_ev(base + 7, 4'b0001, 1'b0);
        push_ev(base + 7 + GAP, 4'b0011, 1'b0);
        rel2 = base + 7 + 2 * GAP;
        wait_edge(rel2 - 1);
        sw_reset = 1'b1;
        push_ev(rel2, 4'b0000, 1'b0);
        wait_edge(rel2);
        sw_reset = 1'b0;
        push_sequence(rel2 - 2);
        wait_edge(rel2 - 2 + DONE_AT);

        // resetb clears everything without a clock edge, fault flags included.
        f = edge_n;
        exp_fault = 4'b0000;
        push_ev(f + 1, 4'b0000, 1'b0);
        resetb = 1'b0;
        #1;
        check_now("async_reset", {rstb_out, seq_done, seq_fault}, 9'd0);
        wait_edge(f + 2);
        g = edge_n;
        resetb = 1'b1;
        push_sequence(g);
        wait_edge(g + DONE_AT + 3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
